// File: rtl/doorlock_disp_ctrl.sv
// Doorlock display controller: owns the four 7-segment digits (com5..com8)
// and arbitrates between the keypad entry buffer, timed OPEn/FAIL messages
// and the lockout pattern. Digits are scanned time-multiplexed.
//
// Input strobes (key_valid, key_clear, result_pass, result_fail) are
// single-cycle pulses with no back-pressure. They are acted on only in IDLE.
// In every other state they are dropped, not queued.
module doorlock_disp_ctrl #(
  parameter int SCAN_DIV    = 50000,
  parameter int MSG_CYCLES  = 50000000,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 250000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_digit,
  input  logic       key_valid,
  input  logic       key_clear,
  input  logic       result_pass,
  input  logic       result_fail,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       com5,
  output logic       com6,
  output logic       com7,
  output logic       com8,
  output logic       lockout,
  output logic [1:0] dbg_state,
  output logic [2:0] dbg_fail_count,
  output logic [2:0] dbg_entry_count
);

  localparam int TMAX = (MSG_CYCLES > LOCK_CYCLES) ? MSG_CYCLES : LOCK_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam int DW   = $clog2(SCAN_DIV);

  localparam logic [TW-1:0] MSG_LOAD  = TW'(MSG_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [2:0]    FAIL_MAX  = 3'(MAX_FAIL);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OPEN = 2'b01;
  localparam logic [1:0] ST_FAIL = 2'b10;
  localparam logic [1:0] ST_LOCK = 2'b11;

  // Segment patterns, bit order {a,b,c,d,e,f,g}
  localparam logic [6:0] GL_O    = 7'b1111110;
  localparam logic [6:0] GL_P    = 7'b1100111;
  localparam logic [6:0] GL_E    = 7'b1001111;
  localparam logic [6:0] GL_N    = 7'b0010101;
  localparam logic [6:0] GL_F    = 7'b1000111;
  localparam logic [6:0] GL_A    = 7'b1110111;
  localparam logic [6:0] GL_I    = 7'b0110000;
  localparam logic [6:0] GL_L    = 7'b0001110;
  localparam logic [6:0] GL_DASH = 7'b0000001;

  logic [DW-1:0] div;
  logic [1:0]    idx;
  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic [2:0]    entry_count;
  logic [2:0]    fail_count;
  logic [3:0]    digits [4];   // digits[0] is the newest entry
  logic [6:0]    glyph;
  logic [1:0]    slot;

  assign dbg_state       = state;
  assign dbg_fail_count  = fail_count;
  assign dbg_entry_count = entry_count;

  function automatic logic [6:0] digit_glyph(input logic [3:0] dig);
    case (dig)
      4'd0:    digit_glyph = 7'b1111110;
      4'd1:    digit_glyph = 7'b0110000;
      4'd2:    digit_glyph = 7'b1101101;
      4'd3:    digit_glyph = 7'b1111001;
      4'd4:    digit_glyph = 7'b0110011;
      4'd5:    digit_glyph = 7'b1011011;
      4'd6:    digit_glyph = 7'b1011111;
      4'd7:    digit_glyph = 7'b1110000;
      4'd8:    digit_glyph = 7'b1111111;
      4'd9:    digit_glyph = 7'b1111011;
      default: digit_glyph = 7'b0000000;
    endcase
  endfunction

  // Free-running scan divider and digit index, never reset by state changes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= '0;
      idx <= 2'd0;
    end else if (div == DIV_LAST) begin
      div <= '0;
      idx <= idx + 2'd1;
    end else begin
      div <= div + DW'(1);
    end
  end

  // Mode FSM: entry buffer, message/lockout timers and failure counting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      timer       <= '0;
      entry_count <= 3'd0;
      fail_count  <= 3'd0;
      lockout     <= 1'b0;
      digits[0]   <= 4'd0;
      digits[1]   <= 4'd0;
      digits[2]   <= 4'd0;
      digits[3]   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Fail beats pass; a result beats any key activity
          if (result_fail) begin
            state       <= ST_FAIL;
            timer       <= MSG_LOAD;
            entry_count <= 3'd0;
            fail_count  <= (fail_count >= FAIL_MAX) ? fail_count : fail_count + 3'd1;
          end else if (result_pass) begin
            state       <= ST_OPEN;
            timer       <= MSG_LOAD;
            entry_count <= 3'd0;
            fail_count  <= 3'd0;
          end else if (key_clear) begin
            entry_count <= 3'd0;
          end else if (key_valid && (key_digit <= 4'd9) && (entry_count < 3'd4)) begin
            digits[3]   <= digits[2];
            digits[2]   <= digits[1];
            digits[1]   <= digits[0];
            digits[0]   <= key_digit;
            entry_count <= entry_count + 3'd1;
          end
        end
        ST_OPEN: begin
          if (timer == '0) state <= ST_IDLE;
          else             timer <= timer - TW'(1);
        end
        ST_FAIL: begin
          if (timer == '0) begin
            if (fail_count == FAIL_MAX) begin
              state   <= ST_LOCK;
              timer   <= LOCK_LOAD;
              lockout <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          if (timer == '0) begin
            state      <= ST_IDLE;
            fail_count <= 3'd0;
            lockout    <= 1'b0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
      endcase
    end
  end

  // Glyph for the currently selected digit; entry buffer is right-aligned
  always_comb begin
    glyph = 7'b0000000;
    slot  = 2'd3 - idx;
    case (state)
      ST_IDLE: begin
        if ({1'b0, slot} < entry_count) glyph = digit_glyph(digits[slot]);
      end
      ST_OPEN: begin
        case (idx)
          2'd0:    glyph = GL_O;
          2'd1:    glyph = GL_P;
          2'd2:    glyph = GL_E;
          default: glyph = GL_N;
        endcase
      end
      ST_FAIL: begin
        case (idx)
          2'd0:    glyph = GL_F;
          2'd1:    glyph = GL_A;
          2'd2:    glyph = GL_I;
          default: glyph = GL_L;
        endcase
      end
      default: glyph = GL_DASH;
    endcase
  end

  // Segment and common lines registered together so they switch in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {a, b, c, d, e, f, g}      <= 7'b0000000;
      {com5, com6, com7, com8}   <= 4'b0000;
    end else begin
      {a, b, c, d, e, f, g}      <= glyph;
      {com5, com6, com7, com8}   <= 4'b1000 >> idx;
    end
  end

endmodule

// File: tb/tb_doorlock_disp_ctrl.sv
// Directed testbench for doorlock_disp_ctrl with small timing parameters.
module tb_doorlock_disp_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int MSG      = 20;
  localparam int MAXF     = 3;
  localparam int LOCKC    = 30;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_OPEN = 2'b01;
  localparam logic [1:0] S_FAIL = 2'b10;
  localparam logic [1:0] S_LOCK = 2'b11;

  localparam logic [6:0] G1 = 7'b0110000;
  localparam logic [6:0] G2 = 7'b1101101;
  localparam logic [6:0] G3 = 7'b1111001;
  localparam logic [6:0] G4 = 7'b0110011;
  localparam logic [6:0] G7 = 7'b1110000;
  localparam logic [6:0] G8 = 7'b1111111;
  localparam logic [6:0] GO = 7'b1111110;
  localparam logic [6:0] GP = 7'b1100111;
  localparam logic [6:0] GE = 7'b1001111;
  localparam logic [6:0] GN = 7'b0010101;
  localparam logic [6:0] GF = 7'b1000111;
  localparam logic [6:0] GA = 7'b1110111;
  localparam logic [6:0] GI = 7'b0110000;
  localparam logic [6:0] GL = 7'b0001110;
  localparam logic [6:0] GD = 7'b0000001;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] key_digit = 4'd0;
  logic key_valid = 1'b0, key_clear = 1'b0, result_pass = 1'b0, result_fail = 1'b0;
  logic a, b, c, d, e, f, g, com5, com6, com7, com8, lockout;
  logic [1:0] dbg_state;
  logic [2:0] dbg_fail_count, dbg_entry_count;
  logic [6:0] seg;
  logic [3:0] com;
  assign seg = {a, b, c, d, e, f, g};
  assign com = {com5, com6, com7, com8};

  doorlock_disp_ctrl #(
    .SCAN_DIV(SCAN_DIV), .MSG_CYCLES(MSG), .MAX_FAIL(MAXF), .LOCK_CYCLES(LOCKC)
  ) dut (
    .clk(clk), .rst(rst), .key_digit(key_digit), .key_valid(key_valid),
    .key_clear(key_clear), .result_pass(result_pass), .result_fail(result_fail),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .com5(com5), .com6(com6), .com7(com7), .com8(com8), .lockout(lockout),
    .dbg_state(dbg_state), .dbg_fail_count(dbg_fail_count),
    .dbg_entry_count(dbg_entry_count)
  );

  int checks = 0;
  int errors = 0;
  logic [6:0] disp [4];
  logic [6:0] exp_g [4];

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    case (com)
      4'b1000: disp[0] = seg;
      4'b0100: disp[1] = seg;
      4'b0010: disp[2] = seg;
      4'b0001: disp[3] = seg;
      default: ;
    endcase
  endtask

  task automatic clear_disp();
    for (int i = 0; i < 4; i++) disp[i] = 'x;
  endtask

  task automatic press_key(input logic [3:0] dig);
    key_digit = dig;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
  endtask

  task automatic do_fail();
    result_fail = 1'b1;
    step();
    result_fail = 1'b0;
    for (int i = 0; i < 100 && dbg_state == S_FAIL; i++) step();
    checks++;
    if (dbg_state == S_FAIL) begin
      errors++;
      $display("FAIL fail_timeout: state %0d still required to leave %0d", dbg_state, S_FAIL);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && dbg_state != S_IDLE; i++) step();
    checks++;
    if (dbg_state != S_IDLE) begin
      errors++;
      $display("FAIL idle_timeout: state %0d required %0d", dbg_state, S_IDLE);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({seg, com, lockout} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 000", {seg, com, lockout});
    end
    checks++;
    if ({dbg_state, dbg_fail_count, dbg_entry_count} !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: got %h required 00", {dbg_state, dbg_fail_count, dbg_entry_count});
    end
    rst = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step();
      checks++;
      if ({com, seg} !== {4'b1000 >> ((n - 1) / 4), 7'd0}) begin
        errors++;
        $display("FAIL scan_seq edge %0d: got com %b seg %b required com %b seg 0",
                 n, com, seg, 4'b1000 >> ((n - 1) / 4));
      end
    end
  endtask

  task automatic test_entry();
    for (int k = 1; k <= 5; k++) press_key(4'(k));
    checks++;
    if (dbg_entry_count !== 3'd4) begin
      errors++;
      $display("FAIL entry_count_full: got %0d required 4", dbg_entry_count);
    end
    clear_disp();
    repeat (16) step();
    exp_g[0] = G1; exp_g[1] = G2; exp_g[2] = G3; exp_g[3] = G4;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (disp[i] !== exp_g[i]) begin
        errors++;
        $display("FAIL entry_glyph com%0d: got %b required %b", i + 5, disp[i], exp_g[i]);
      end
    end
    key_clear = 1'b1;
    step();
    key_clear = 1'b0;
    clear_disp();
    repeat (16) step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (disp[i] !== 7'd0) begin
        errors++;
        $display("FAIL clear_glyph com%0d: got %b required 0000000", i + 5, disp[i]);
      end
    end
    press_key(4'd12);
    checks++;
    if (dbg_entry_count !== 3'd0) begin
      errors++;
      $display("FAIL bad_digit_ignored: got %0d required 0", dbg_entry_count);
    end
    press_key(4'd9);
    checks++;
    if (dbg_entry_count !== 3'd1) begin
      errors++;
      $display("FAIL digit9_accepted: got %0d required 1", dbg_entry_count);
    end
    key_clear = 1'b1;
    key_valid = 1'b1;
    key_digit = 4'd5;
    step();
    key_clear = 1'b0;
    key_valid = 1'b0;
    checks++;
    if (dbg_entry_count !== 3'd0) begin
      errors++;
      $display("FAIL clear_beats_valid: got %0d required 0", dbg_entry_count);
    end
  endtask

  task automatic test_open();
    press_key(4'd7);
    press_key(4'd8);
    clear_disp();
    repeat (16) step();
    exp_g[0] = 7'd0; exp_g[1] = 7'd0; exp_g[2] = G7; exp_g[3] = G8;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (disp[i] !== exp_g[i]) begin
        errors++;
        $display("FAIL entry2_glyph com%0d: got %b required %b", i + 5, disp[i], exp_g[i]);
      end
    end
    result_pass = 1'b1;
    step();
    result_pass = 1'b0;
    checks++;
    if (dbg_state !== S_OPEN) begin
      errors++;
      $display("FAIL open_entry: state %0d required %0d", dbg_state, S_OPEN);
    end
    clear_disp();
    for (int k = 2; k <= 20; k++) step();
    checks++;
    if (dbg_state !== S_OPEN) begin
      errors++;
      $display("FAIL open_hold_20: state %0d required %0d", dbg_state, S_OPEN);
    end
    exp_g[0] = GO; exp_g[1] = GP; exp_g[2] = GE; exp_g[3] = GN;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (disp[i] !== exp_g[i]) begin
        errors++;
        $display("FAIL open_glyph com%0d: got %b required %b", i + 5, disp[i], exp_g[i]);
      end
    end
    step();
    checks++;
    if ({dbg_state, dbg_entry_count, dbg_fail_count} !== {S_IDLE, 3'd0, 3'd0}) begin
      errors++;
      $display("FAIL open_exit_21: got state %0d count %0d fails %0d required 0 0 0",
               dbg_state, dbg_entry_count, dbg_fail_count);
    end
  endtask

  task automatic test_simultaneous();
    result_pass = 1'b1;
    result_fail = 1'b1;
    step();
    result_pass = 1'b0;
    result_fail = 1'b0;
    checks++;
    if ({dbg_state, dbg_fail_count} !== {S_FAIL, 3'd1}) begin
      errors++;
      $display("FAIL simul_fail_wins: got state %0d fails %0d required %0d 1",
               dbg_state, dbg_fail_count, S_FAIL);
    end
    clear_disp();
    repeat (16) step();
    exp_g[0] = GF; exp_g[1] = GA; exp_g[2] = GI; exp_g[3] = GL;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (disp[i] !== exp_g[i]) begin
        errors++;
        $display("FAIL fail_glyph com%0d: got %b required %b", i + 5, disp[i], exp_g[i]);
      end
    end
    wait_idle();
  endtask

  task automatic test_lockout();
    int lock_edge;
    int high;
    do_fail();
    checks++;
    if ({dbg_state, dbg_fail_count} !== {S_IDLE, 3'd2}) begin
      errors++;
      $display("FAIL second_fail: got state %0d fails %0d required 0 2", dbg_state, dbg_fail_count);
    end
    result_fail = 1'b1;
    step();
    result_fail = 1'b0;
    lock_edge = 0;
    for (int k = 2; k <= 40; k++) begin
      step();
      if (lockout) begin
        lock_edge = k;
        break;
      end
    end
    checks++;
    if (lock_edge != 21) begin
      errors++;
      $display("FAIL lock_entry_edge: got %0d required 21", lock_edge);
    end
    high = 1;
    clear_disp();
    for (int i = 0; i < 100; i++) begin
      if (i == 5) begin
        key_digit = 4'd6;
        key_valid = 1'b1;
        result_pass = 1'b1;
      end
      if (i == 6) begin
        key_valid = 1'b0;
        result_pass = 1'b0;
      end
      step();
      if (lockout) high++;
      else break;
    end
    checks++;
    if (high != LOCKC) begin
      errors++;
      $display("FAIL lock_duration: got %0d required %0d", high, LOCKC);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (disp[i] !== GD) begin
        errors++;
        $display("FAIL lock_glyph com%0d: got %b required %b", i + 5, disp[i], GD);
      end
    end
    checks++;
    if ({dbg_state, dbg_fail_count, dbg_entry_count, lockout} !== {S_IDLE, 3'd0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL lock_exit: got state %0d fails %0d count %0d lockout %0d required 0 0 0 0",
               dbg_state, dbg_fail_count, dbg_entry_count, lockout);
    end
  endtask

  task automatic test_pass_resets();
    do_fail();
    do_fail();
    checks++;
    if (dbg_fail_count !== 3'd2) begin
      errors++;
      $display("FAIL pass_pre_fails: got %0d required 2", dbg_fail_count);
    end
    result_pass = 1'b1;
    step();
    result_pass = 1'b0;
    wait_idle();
    checks++;
    if (dbg_fail_count !== 3'd0) begin
      errors++;
      $display("FAIL pass_clears_fails: got %0d required 0", dbg_fail_count);
    end
    do_fail();
    checks++;
    if ({dbg_state, dbg_fail_count, lockout} !== {S_IDLE, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL pass_then_fail: got state %0d fails %0d lockout %0d required 0 1 0",
               dbg_state, dbg_fail_count, lockout);
    end
  endtask

  task automatic test_reset_mid_lock();
    do_fail();
    do_fail();
    checks++;
    if ({dbg_state, lockout} !== {S_LOCK, 1'b1}) begin
      errors++;
      $display("FAIL relock_entry: got state %0d lockout %0d required 3 1", dbg_state, lockout);
    end
    repeat (5) step();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({seg, com, lockout} !== 12'd0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %h required 000", {seg, com, lockout});
    end
    checks++;
    if ({dbg_state, dbg_fail_count, dbg_entry_count} !== 8'd0) begin
      errors++;
      $display("FAIL async_reset_state: got %h required 00", {dbg_state, dbg_fail_count, dbg_entry_count});
    end
    @(posedge clk);
    #1 rst = 1'b1;
    do_fail();
    do_fail();
    checks++;
    if ({dbg_state, dbg_fail_count, lockout} !== {S_IDLE, 3'd2, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_two_fails: got state %0d fails %0d lockout %0d required 0 2 0",
               dbg_state, dbg_fail_count, lockout);
    end
    do_fail();
    checks++;
    if ({dbg_state, lockout} !== {S_LOCK, 1'b1}) begin
      errors++;
      $display("FAIL post_reset_third_locks: got state %0d lockout %0d required 3 1", dbg_state, lockout);
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_open();
    test_simultaneous();
    test_lockout();
    test_pass_resets();
    test_reset_mid_lock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/doorlock_disp_ctrl.md
Name: doorlock_disp_ctrl

Overview:
- Display controller/arbiter for the doorlock's four 7-segment digits (com5..com8).
- Shares the display between three sources:
  - the live keypad entry buffer
  - timed "OPEN" / "FAIL" result messages
  - a lockout pattern after repeated failures
- Scans the digits time-multiplexed and sequences message hold times.
- Replaces the per-message AND-gated display enables with one owner of the segment/common lines.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit stays selected (≥2).
- MSG_CYCLES, 50000000, clk cycles a result message is held (≥2).
- MAX_FAIL, 3, consecutive failures that trigger lockout (1..7).
- LOCK_CYCLES, 250000000, clk cycles lockout lasts (≥2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- key_digit  input  4  BCD digit from keypad decoder (0..9; 10..15 ignored).
- key_valid  input  1  one-cycle strobe, key_digit valid.
- key_clear  input  1  one-cycle strobe, clears entry buffer.
- result_pass  input  1  one-cycle strobe, password accepted.
- result_fail  input  1  one-cycle strobe, password rejected.
- a,b,c,d,e,f,g  output  1 each  segment drives, active-high, registered.
- com5,com6,com7,com8  output  1 each  digit selects, active-high, one-hot while scanning, registered.
- lockout  output  1  high while in LOCK state, registered.

Behaviour:
- Reset (rst=0, async):
  - all outputs 0
  - state=IDLE, entry count=0, fail count=0
  - scan index=0, divider=0, timer=0
- Scan:
  - Divider counts 0..SCAN_DIV-1 continuously in every state; at SCAN_DIV-1 it wraps and the index advances 0→1→2→3→0.
  - Index 0/1/2/3 drives com5/com6/com7/com8.
  - com and a..g update together, one cycle after the index/glyph change, so there is no ghosting.
- Glyphs (a..g as segment set):
  - Digits 0..9 use standard encoding.
  - O=abcdef, P=abefg, E=adefg, n=ceg, F=aefg, A=abcefg, I=bc, L=def, '-'=g, blank=none.
- States:
  - IDLE
    - Shows the entry buffer right-aligned: newest digit on com8, unused positions blank; count=0 shows all blank.
    - key_valid with key_digit≤9 and count<4: shift digit in, count+1.
    - key_valid at count=4, or with a digit >9: ignored.
    - key_clear: count=0. If key_clear and key_valid occur in the same cycle, key_clear wins.
    - result_fail → SHOW_FAIL. If result_pass and result_fail occur in the same cycle, fail wins.
    - result_pass alone → SHOW_OPEN.
  - SHOW_OPEN
    - Shows "OPEn", com5..com8.
    - On entry: timer=MSG_CYCLES-1, entry buffer cleared, fail count=0.
    - Timer decrements each cycle; at 0 the next state is IDLE.
  - SHOW_FAIL
    - Shows "FAIL".
    - On entry: timer=MSG_CYCLES-1, buffer cleared, fail count+1 (saturating at MAX_FAIL).
    - At timer 0: go to LOCK if fail count==MAX_FAIL, else IDLE.
  - LOCK
    - Shows "----"; lockout=1.
    - On entry: timer=LOCK_CYCLES-1.
    - At timer 0: state=IDLE, fail count=0, lockout=0 on the next cycle.
- Transition timing:
  - The state changes the cycle after the strobe.
  - The new message appears at the next scan refresh of each digit; the scan phase is not reset.
- In SHOW_OPEN, SHOW_FAIL and LOCK: key_valid, key_clear, result_pass and result_fail are all ignored (no retrigger, no buffering).
- Timer width: ceil(log2(max(MSG_CYCLES, LOCK_CYCLES))) bits. Entry buffer: 4×4 bits.
- Reset asserted mid-message or mid-lockout: immediate return to the reset values, lockout=0.

Test Plan:
- Entry and clear:
  - Stimulus: reset release with SCAN_DIV=4; key_valid digits 1,2,3,4,5.
  - Required: com sequence com5→com8 every 4 cycles; com8 shows "4"=bcfg and com5 shows "1"=bc; the 5th digit is ignored.
  - Then key_clear → all segments 0 on every com.
- Open message:
  - Stimulus: MSG_CYCLES=20; result_pass in IDLE with count=2.
  - Required: "OPEn" displayed (com5 glyph abcdef); return to IDLE exactly 21 cycles after the strobe; buffer empty.
- Simultaneous strobes:
  - Stimulus: result_pass and result_fail in the same cycle.
  - Required: "FAIL" shown (com5 glyph aefg); fail count=1.
- Lockout:
  - Stimulus: MAX_FAIL=3, LOCK_CYCLES=30; three fails separated by message timeouts.
  - Required: after the 3rd FAIL, lockout=1 for 30 cycles with g-only glyph on all digits; key_valid and result_pass during lock have no effect; then lockout=0, IDLE, fail count=0.
- Pass resets fail count:
  - Stimulus: fail, fail, pass, fail.
  - Required: no lockout; fail count=1.
- Reset mid-lockout:
  - Stimulus: assert rst during LOCK.
  - Required: all outputs 0 asynchronously; after release, state is IDLE and three new fails are needed to lock.
